prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Boot-time program loader sitting upstream of the SUBLEQ core on the shared memory bus.
//  Accepts a byte stream (from UART/host bridge) carrying a word count plus a program image.
//  Writes the image word-by-word into memory from BASE_ADDR, then hands the bus to the core.
//  Hand-over is done by raising cpu_en and releasing core_rst_n.
// PARAMETERS
//  BASE_ADDR   32'h0   byte address of first program word; increments by 4 per word
//  MAX_WORDS   1024    largest accepted word count; larger header -> ERROR
// PORTS
//  clk          in     1   system clock
//  rst          in     1   asynchronous, active-low reset
//  in_valid     in     1   byte stream valid
//  in_data      in     8   byte stream data
//  in_ready     out    1   loader accepts byte this cycle (in_valid & in_ready)
//  load_req     in     1   1-cycle pulse in RUN/ERROR: re-enter HDR, take bus back from core
//  cpu_en       out    1   1 = core owns bus; loader outputs high-Z
//  core_rst_n   out    1   core reset (active-low); low whenever cpu_en=0
//  mem_we       inout  1   driven when cpu_en=0, else high-Z
//  mem_addr     inout  32  driven when cpu_en=0, else high-Z
//  mem_data     inout  32  driven only when loader mem_we=1, else high-Z
//  load_done    out    1   level: image written, core running
//  load_err     out    1   level: header or checksum failure; sticky until load_req/reset
// BEHAVIOUR
//  Reset (async): state=HDR; in_ready=1; cpu_en=0; core_rst_n=0; mem_we=0; mem_addr=BASE_ADDR;
//   load_done=0; load_err=0; byte/word counters=0. Reset mid-load aborts; partial image ignored.
//  FSM: HDR -> DATA -> WRITE -> DATA ... -> [CHK] -> RUN; ERROR from HDR/CHK.
//  HDR: 4 bytes, first byte = count[31:24] (big-endian). After 4th byte:
//   count==0 -> RUN (or CHK); count>MAX_WORDS -> ERROR; else -> DATA.
//  DATA: collect 4 bytes; byte k (0..3 in stream order) -> word lane [8k+7:8k] (byte order
//   preserved as memory image; the core does its own byte swap). After 4th byte -> WRITE.
//  WRITE: exactly 1 cycle: mem_we=1, mem_addr=BASE_ADDR+4*idx, mem_data=word, in_ready=0.
//   Next cycle idx++, addr+=4; idx==count -> RUN/CHK else DATA. Address wraps mod 2^32.
//  Throughput: 1 word per 5 cycles max (4 accepted bytes + WRITE); stalls on in_valid=0 hold state.
//  RUN: cpu_en=1, core_rst_n=1 on the same edge; load_done=1; in_ready=0; extra bytes ignored.
//  ERROR: cpu_en=0, core_rst_n=0, load_err=1, in_ready=0, mem_we=0.
//  load_req in RUN/ERROR: next cycle cpu_en=0, core_rst_n=0, flags clear, counters clear,
//   state=HDR. load_req in any other state ignored. Simultaneous load_req + in_valid in RUN:
//   byte is not accepted (in_ready=0 that cycle).
//  When cpu_en=0 and not WRITE, mem_we=0 driven, mem_data high-Z.
// CONFIGURATION
//  PROG_LOADER_CHECKSUM_EN defined: after last word, CHK takes 4 more bytes (big-endian)
//   = mod-2^32 sum of all words as written (lane-order value). Match -> RUN; mismatch -> ERROR.
//   Count 0: expected sum 0.
//  Undefined: no CHK state; last WRITE (or count 0 header) goes straight to RUN.
// STRUCTURE
//  Shared package: FSM state encoding (one-hot, matching core style), BYTES_PER_WORD=4,
//   WORD_W=32, bus-ownership helper macros.
//  One sub-module natural: byte_packer (4-byte shift/assemble with byte counter, done pulse);
//   reused for header, data words and checksum.
// TESTING
//  T1: rst low mid-stream, release -> all outputs at reset values, mem_* driven, cpu_en=0.
//  T2: header 00 00 00 02, bytes 11 22 33 44 55 66 77 88 -> writes [0]=32'h44332211,
//   [4]=32'h88776655; cpu_en=1, core_rst_n=1 cycle after 2nd WRITE; bus high-Z after.
//  T3: header 00 00 04 01 (1025 > MAX_WORDS) -> load_err=1, no mem_we pulse, cpu_en=0.
//  T4: header count 0 -> RUN immediately (no-checksum build), zero writes.
//  T5: random in_valid gaps over 16 words -> memory image identical, one WRITE per word.
//  T6 (CHECKSUM_EN): correct sum -> RUN; sum off by 1 -> ERROR; then load_req -> HDR, reload OK.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader shared types: one-hot FSM encoding, widths, bus helpers.
// Optional checksum stage enabled by defining PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  localparam int ST_HDR   = 0;
  localparam int ST_DATA  = 1;
  localparam int ST_WRITE = 2;
  localparam int ST_CHK   = 3;
  localparam int ST_RUN   = 4;
  localparam int ST_ERR   = 5;
  localparam int ST_N     = 6;

  typedef enum logic [ST_N-1:0] {
    S_HDR   = 6'b000001,
    S_DATA  = 6'b000010,
    S_WRITE = 6'b000100,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK   = 6'b001000,
`endif
    S_RUN   = 6'b010000,
    S_ERR   = 6'b100000
  } state_t;

  function automatic logic core_owns_bus(state_t s);
    return s[ST_RUN];
  endfunction

  function automatic logic takes_bytes(state_t s);
    return s[ST_HDR] | s[ST_DATA] | s[ST_CHK];
  endfunction

  function automatic logic [WORD_W-1:0] bswap(
    logic [WORD_W-1:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader control interface: byte stream handshake,
// reload request and core hand-over / status levels.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              load_req;
  logic              cpu_en;
  logic              core_rst_n;
  logic              load_done;
  logic              load_err;

  modport master (
    output in_valid, in_data, load_req,
    input  in_ready, cpu_en, core_rst_n,
    input  load_done, load_err
  );

  modport slave (
    input  in_valid, in_data, load_req,
    output in_ready, cpu_en, core_rst_n,
    output load_done, load_err
  );

endinterface

// File: rtl/prog_loader_packer.sv
// Byte packer: assembles 4 stream bytes into a word, byte k in lane k.
// word_o already includes the byte accepted this cycle; done_o marks the 4th.
module prog_loader_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;

  // Place the incoming byte into its lane and advance the byte counter.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (en_i) begin
      word_d[{cnt_q, 3'b000} +: BYTE_W] = byte_i;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Packer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_d;
  assign done_o = en_i & ~clr_i &
                  (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot loader: streams a counted program image into memory, then hands
// the bus to the core. PROG_LOADER_CHECKSUM_EN adds a trailing sum check.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  prog_loader_if.slave bus,
  inout  wire         mem_we,
  inout  wire  [31:0] mem_addr,
  inout  wire  [31:0] mem_data
);

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t LAST_NEXT = S_CHK;
`else
  localparam state_t LAST_NEXT = S_RUN;
`endif

  state_t            state_q, state_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] sum_q, sum_d;
  logic [WORD_W-1:0] pk_word;
  logic [WORD_W-1:0] be_word;
  logic              pk_done;
  logic              pk_clr;
  logic              acc;
  logic              owns;

  assign acc     = bus.in_valid & bus.in_ready;
  assign be_word = bswap(pk_word);

  prog_loader_packer u_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (pk_clr),
    .en_i   (acc),
    .byte_i (bus.in_data),
    .word_o (pk_word),
    .done_o (pk_done)
  );

  // Next-state logic: header decode, word capture, write, sum check, reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    word_d  = word_q;
    sum_d   = sum_q;
    pk_clr  = 1'b0;
    unique case (1'b1)
      state_q[ST_HDR]: begin
        if (pk_done) begin
          cnt_d = be_word;
          if (be_word == '0)
            state_d = LAST_NEXT;
          else if (be_word > WORD_W'(MAX_WORDS))
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      state_q[ST_DATA]: begin
        if (pk_done) begin
          word_d  = pk_word;
          state_d = S_WRITE;
        end
      end
      state_q[ST_WRITE]: begin
        idx_d   = idx_q + 1'b1;
        addr_d  = addr_q + 32'd4;
        sum_d   = sum_q + word_q;
        state_d = (idx_d == cnt_q) ? LAST_NEXT : S_DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      state_q[ST_CHK]: begin
        if (pk_done)
          state_d = (be_word == sum_q) ? S_RUN : S_ERR;
      end
`endif
      state_q[ST_RUN], state_q[ST_ERR]: begin
        if (bus.load_req) begin
          state_d = S_HDR;
          cnt_d   = '0;
          idx_d   = '0;
          addr_d  = BASE_ADDR;
          sum_d   = '0;
          pk_clr  = 1'b1;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  // Loader state registers; reset aborts any partial load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HDR;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      word_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      sum_q   <= sum_d;
    end
  end

  assign owns           = core_owns_bus(state_q);
  assign bus.in_ready   = takes_bytes(state_q);
  assign bus.cpu_en     = owns;
  assign bus.core_rst_n = owns;
  assign bus.load_done  = state_q[ST_RUN];
  assign bus.load_err   = state_q[ST_ERR];

  assign mem_we   = owns ? 1'bz : state_q[ST_WRITE];
  assign mem_addr = owns ? {WORD_W{1'bz}} : addr_q;
  assign mem_data = state_q[ST_WRITE] ? word_q
                                      : {WORD_W{1'bz}};

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed loads with a write
// scoreboard, header errors, reset abort and reload requests.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if bus();
  wire        mem_we;
  wire [31:0] mem_addr;
  wire [31:0] mem_data;

  prog_loader #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (1024)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] img[$];
  int          checks = 0;
  int          errors = 0;
  int          nwr    = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // write monitor: every loader write must match the oldest expected one
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      nwr++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: got write @%h expected none",
               mem_addr);
      end
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_data, e.d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("byte_accept", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] h);
    for (int k = 3; k >= 0; k--) send_byte(h[8*k +: 8], 0);
  endtask

  task automatic load_prog(input int n, input int maxgap,
                           input logic [31:0] delta);
    logic [31:0] sum;
    logic [31:0] w;
    sum = '0;
    send_hdr(32'(n));
    for (int i = 0; i < n; i++) begin
      w = img[i];
      sb.push_back({BASE + 32'(4 * i), w});
      sum = sum + w;
      for (int k = 0; k < 4; k++)
        send_byte(w[8*k +: 8], int'($urandom_range(maxgap, 0)));
    end
    sum = sum + delta;
`ifdef PROG_LOADER_CHECKSUM_EN
    send_hdr(sum);
`endif
  endtask

  task automatic wait_end(input string tag, input logic exp_err);
    int n;
    n = 0;
    while (bus.cpu_en !== 1'b1 && bus.load_err !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_err"},    32'(bus.load_err),   32'(exp_err));
    chk({tag, "_cpu_en"}, 32'(bus.cpu_en),     32'(!exp_err));
    chk({tag, "_crst"},   32'(bus.core_rst_n), 32'(!exp_err));
    chk({tag, "_done"},   32'(bus.load_done),  32'(!exp_err));
    chk({tag, "_sb"},     32'(sb.size()),      32'h0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"},  32'(bus.in_ready),   32'h1);
    chk({tag, "_cpu_en"}, 32'(bus.cpu_en),     32'h0);
    chk({tag, "_crst"},   32'(bus.core_rst_n), 32'h0);
    chk({tag, "_we"},     32'(mem_we),         32'h0);
    chk({tag, "_addr"},   mem_addr,            BASE);
    chk({tag, "_done"},   32'(bus.load_done),  32'h0);
    chk({tag, "_err"},    32'(bus.load_err),   32'h0);
  endtask

  task automatic pulse_req(input string tag);
    bus.load_req = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    chk({tag, "_req_rdy"}, 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    chk_idle(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.load_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("rst0");
    rst = 1'b1;
    @(negedge clk);

    // T1: reset in the middle of a load
    send_hdr(32'd2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    #2 rst = 1'b0;
    #1 chk_idle("t1");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_nwr", 32'(nwr), 32'h0);

    // T2: two-word image
    img = {32'h44332211, 32'h88776655};
    nwr = 0;
    load_prog(2, 0, 32'h0);
`ifndef PROG_LOADER_CHECKSUM_EN
    chk("t2_we",     32'(mem_we),     32'h1);
    chk("t2_addr",   mem_addr,        BASE + 32'h4);
    chk("t2_data",   mem_data,        32'h88776655);
    chk("t2_rdy",    32'(bus.in_ready), 32'h0);
    chk("t2_pre_en", 32'(bus.cpu_en), 32'h0);
    @(negedge clk);
    chk("t2_run_en", 32'(bus.cpu_en), 32'h1);
`endif
    wait_end("t2", 1'b0);
    chk("t2_nwr", 32'(nwr), 32'h2);
    chk("t2_bus_rel", 32'(mem_we === 1'b1), 32'h0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    chk("t2_xtra_rdy", 32'(bus.in_ready), 32'h0);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t2_xtra_run", 32'(bus.cpu_en), 32'h1);
    pulse_req("t2r");

    // T3: count above MAX_WORDS
    nwr = 0;
    send_hdr(32'd1025);
    chk("t3_err",    32'(bus.load_err),   32'h1);
    chk("t3_cpu_en", 32'(bus.cpu_en),     32'h0);
    chk("t3_crst",   32'(bus.core_rst_n), 32'h0);
    chk("t3_rdy",    32'(bus.in_ready),   32'h0);
    repeat (3) @(negedge clk);
    chk("t3_sticky", 32'(bus.load_err), 32'h1);
    chk("t3_nwr",    32'(nwr), 32'h0);
    pulse_req("t3r");

    // count equal to MAX_WORDS is accepted
    send_hdr(32'd1024);
    chk("max_err", 32'(bus.load_err), 32'h0);
    chk("max_rdy", 32'(bus.in_ready), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // T4: empty image
    img.delete();
    nwr = 0;
    load_prog(0, 0, 32'h0);
`ifndef PROG_LOADER_CHECKSUM_EN
    chk("t4_imm_en", 32'(bus.cpu_en), 32'h1);
`endif
    wait_end("t4", 1'b0);
    chk("t4_nwr", 32'(nwr), 32'h0);
    pulse_req("t4r");

    // T5: 16 words with random in_valid gaps
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back($urandom());
    nwr = 0;
    load_prog(16, 3, 32'h0);
    wait_end("t5", 1'b0);
    chk("t5_nwr", 32'(nwr), 32'd16);
    pulse_req("t5r");

`ifdef PROG_LOADER_CHECKSUM_EN
    // T6: bad then good checksum
    img = {32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF};
    nwr = 0;
    load_prog(3, 1, 32'h1);
    wait_end("t6bad", 1'b1);
    chk("t6bad_nwr", 32'(nwr), 32'd3);
    pulse_req("t6r");
    nwr = 0;
    load_prog(3, 1, 32'h0);
    wait_end("t6ok", 1'b0);
    chk("t6ok_nwr", 32'(nwr), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
